// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data RAM between the pipeline memory stage (cpu) and the debug/boot loader (dbg).
// cpu has fixed priority; a starvation counter forces one dbg access through, and halt gives dbg exclusive use.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  typedef enum logic [1:0] {ST_RUN, ST_FORCE, ST_HALT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  state_t            state;
  owner_t            rd_owner;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_won;
  logic              dbg_won;
  logic              dbg_lost;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // Grant follows the registered state only, so a late halted never cancels an access already won.
  always_comb begin
    cpu_won = 1'b0;
    dbg_won = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_RUN: begin
          cpu_won = cpu_req;
          dbg_won = dbg_req & ~cpu_req;
        end
        ST_FORCE: begin
          dbg_won = dbg_req;
          cpu_won = cpu_req & ~dbg_req;
        end
        ST_HALT: begin
          dbg_won = dbg_req;
        end
        default: begin
          cpu_won = 1'b0;
          dbg_won = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_won) begin
      mem_we = cpu_we;
      mem_re = ~cpu_we;
    end else if (dbg_won) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_won;
  assign dbg_gnt   = dbg_won;
  assign dbg_lost  = dbg_req & ~dbg_won;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      starve_cnt <= '0;
    end else begin
      if (!dbg_req || dbg_won) begin
        starve_cnt <= '0;
      end else if (state == ST_RUN && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      if (halted) begin
        state <= ST_HALT;
      end else begin
        unique case (state)
          ST_HALT: begin
            state      <= ST_RUN;
            starve_cnt <= '0;
          end
          ST_RUN: begin
            if (dbg_lost && starve_cnt == CNT_LAST) state <= ST_FORCE;
          end
          ST_FORCE: begin
            if (dbg_won || !dbg_req) begin
              state      <= ST_RUN;
              starve_cnt <= '0;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

  // RAM data arrives the cycle after mem_re; pass it straight through then keep a copy so rdata holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner    <= OWN_NONE;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (mem_re) rd_owner <= cpu_won ? OWN_CPU : OWN_DBG;
      else        rd_owner <= OWN_NONE;
      if (rd_owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (rd_owner == OWN_DBG) dbg_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dbg_rvalid = (rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// The model treats arbitration as "dbg gets priority once it has lost STARVE_MAX times in a row".
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              halted;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .halted(halted),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM environment
  bit [DATA_W-1:0] ram [65536];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Behavioural reference model
  bit [DATA_W-1:0] smem [65536];
  int              losses = 0;
  bit              halt_mode = 1'b0;
  bit              m_cpu_rv = 1'b0, m_dbg_rv = 1'b0;
  logic [DATA_W-1:0] m_cpu_rd = '0, m_dbg_rd = '0;
  logic            exp_cpu_won, exp_dbg_won;

  always_comb begin
    exp_cpu_won = 1'b0;
    exp_dbg_won = 1'b0;
    if (rst) begin
      exp_cpu_won = 1'b0;
    end else if (halt_mode) begin
      exp_dbg_won = dbg_req;
    end else if (losses >= STARVE_MAX) begin
      exp_dbg_won = dbg_req;
      exp_cpu_won = cpu_req && !dbg_req;
    end else begin
      exp_cpu_won = cpu_req;
      exp_dbg_won = dbg_req && !cpu_req;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      losses    <= 0;
      halt_mode <= 1'b0;
      m_cpu_rv  <= 1'b0;
      m_dbg_rv  <= 1'b0;
      m_cpu_rd  <= '0;
      m_dbg_rd  <= '0;
    end else begin
      m_cpu_rv <= exp_cpu_won && !cpu_we;
      m_dbg_rv <= exp_dbg_won && !dbg_we;
      if (exp_cpu_won && !cpu_we) m_cpu_rd <= smem[cpu_addr];
      if (exp_dbg_won && !dbg_we) m_dbg_rd <= smem[dbg_addr];
      if (exp_cpu_won && cpu_we)  smem[cpu_addr] <= cpu_wdata;
      if (exp_dbg_won && dbg_we)  smem[dbg_addr] <= dbg_wdata;
      if (halt_mode && !halted)              losses <= 0;
      else if (exp_dbg_won || !dbg_req)      losses <= 0;
      else if (!halt_mode && losses < STARVE_MAX) losses <= losses + 1;
      halt_mode <= halted;
    end
  end

  task automatic drive_cpu(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0; halted = 1'b0;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #1 rst = 1'b1;
    drive_cpu(1'b1, 1'b0, 16'h0007, 16'h0);
    drive_dbg(1'b1, 1'b0, 16'h0008, 16'h0);
    @(negedge clk); #2;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_re: got %b want 0", mem_re); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_stall: got %b want 1", cpu_stall); end
    checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got cpu=%b dbg=%b want 0/0", cpu_rvalid, dbg_rvalid); end
    checks++; if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rdata: got cpu=%h dbg=%h want 0/0", cpu_rdata, dbg_rdata); end
    @(negedge clk);
    rst = 1'b0;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
  endtask

  task automatic test_cpu_load();
    drive_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    #2;
    checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_prestore: got we=%b stall=%b want 1/0", mem_we, cpu_stall); end
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
    #2;
    checks++; if (mem_re !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_issue: got re=%b stall=%b want 1/0", mem_re, cpu_stall); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("[TB] FAIL load_addr: got %h want 0010", mem_addr); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL load_rvalid: got cpu=%b dbg=%b want 1/0", cpu_rvalid, dbg_rvalid); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL load_rdata: got %h want beef", cpu_rdata); end
    @(negedge clk); #2;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL load_hold: got rvalid=%b rdata=%h want 0/beef", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit seen_gnt = 1'b0;
    logic exp_g;
    for (int i = 0; i < 6; i++) begin
      drive_cpu(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0);
      drive_dbg(!seen_gnt, 1'b1, 16'h0020, 16'h1234);
      #2;
      exp_g = (i == 4);
      checks++; if (dbg_gnt !== exp_g || cpu_stall !== exp_g) begin errors++; $display("[TB] FAIL starve_cycle%0d: got gnt=%b stall=%b want %b/%b", i, dbg_gnt, cpu_stall, exp_g, exp_g); end
      if (i == 4) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL starve_force_write: got we=%b addr=%h data=%h want 1/0020/1234", mem_we, mem_addr, mem_wdata); end
      end else begin
        checks++; if (mem_re !== 1'b1 || mem_addr !== 16'(16'h0100 + i)) begin errors++; $display("[TB] FAIL starve_cpu_read%0d: got re=%b addr=%h want 1/%h", i, mem_re, mem_addr, 16'(16'h0100 + i)); end
      end
      if (dbg_gnt) seen_gnt = 1'b1;
      @(negedge clk);
    end
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
  endtask

  task automatic test_store_then_read();
    drive_cpu(1'b1, 1'b1, 16'h0005, 16'hAAAA);
    drive_dbg(1'b1, 1'b0, 16'h0005, 16'h0);
    #2;
    checks++; if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 16'hAAAA) begin errors++; $display("[TB] FAIL str_store_first: got stall=%b gnt=%b we=%b wdata=%h want 0/0/1/aaaa", cpu_stall, dbg_gnt, mem_we, mem_wdata); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (dbg_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 16'h0005) begin errors++; $display("[TB] FAIL str_dbg_read: got gnt=%b re=%b addr=%h want 1/1/0005", dbg_gnt, mem_re, mem_addr); end
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== 16'hAAAA) begin errors++; $display("[TB] FAIL str_dbg_return: got dv=%b cv=%b data=%h want 1/0/aaaa", dbg_rvalid, cpu_rvalid, dbg_rdata); end
    @(negedge clk);
  endtask

  task automatic test_halt_alternate();
    drive_cpu(1'b1, 1'b1, 16'h0001, 16'h1111);
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 16'h0002, 16'h2222);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    halted = 1'b1;
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 16'h0001, 16'h0);
    drive_dbg(1'b1, 1'b0, 16'h0002, 16'h0);
    #2;
    checks++; if (cpu_stall !== 1'b1 || dbg_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("[TB] FAIL halt_dbg_only: got stall=%b gnt=%b re=%b addr=%h want 1/1/1/0002", cpu_stall, dbg_gnt, mem_re, mem_addr); end
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== 16'h2222 || cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL halt_dbg_return: got dv=%b cv=%b data=%h stall=%b want 1/0/2222/1", dbg_rvalid, cpu_rvalid, dbg_rdata, cpu_stall); end
    @(negedge clk);
    halted = 1'b0;
    #2;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL halt_release_lag: got stall=%b want 1", cpu_stall); end
    @(negedge clk); #2;
    checks++; if (cpu_stall !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("[TB] FAIL alt_cpu_issue: got stall=%b re=%b addr=%h want 0/1/0001", cpu_stall, mem_re, mem_addr); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b1, 1'b0, 16'h0002, 16'h0);
    #2;
    checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== 16'h1111 || dbg_gnt !== 1'b1) begin errors++; $display("[TB] FAIL alt_cpu_return: got cv=%b dv=%b data=%h gnt=%b want 1/0/1111/1", cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_gnt); end
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 16'h0001, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== 16'h2222 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL alt_dbg_return: got dv=%b cv=%b data=%h stall=%b want 1/0/2222/0", dbg_rvalid, cpu_rvalid, dbg_rdata, cpu_stall); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== 16'h1111) begin errors++; $display("[TB] FAIL alt_cpu_return2: got cv=%b dv=%b data=%h want 1/0/1111", cpu_rvalid, dbg_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_halt_writes();
    int we_pulses = 0;
    halted = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive_cpu(1'b1, 1'b0, 16'h0030, 16'h0);
      drive_dbg(1'b1, 1'b1, 16'(i), 16'(16'hD000 + i));
      #2;
      checks++; if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL hwr_cycle%0d: got gnt=%b stall=%b want 1/1", i, dbg_gnt, cpu_stall); end
      if (mem_we === 1'b1) we_pulses++;
      @(negedge clk);
    end
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL hwr_idle: got stall=%b we=%b want 1/0", cpu_stall, mem_we); end
    checks++; if (we_pulses != 4) begin errors++; $display("[TB] FAIL hwr_pulses: got %0d want 4", we_pulses); end
    @(negedge clk);
    halted = 1'b0;
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 16'h0002, 16'h0);
    #2;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL hwr_cpu_resume: got stall=%b want 0", cpu_stall); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hD002) begin errors++; $display("[TB] FAIL hwr_readback: got cv=%b data=%h want 1/d002", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
      drive_dbg(1'b1, 1'b0, 16'h0040, 16'h0);
      @(negedge clk);
    end
    rst = 1'b1;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || dbg_gnt !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("[TB] FAIL rmid_in_reset: got cv=%b dv=%b gnt=%b re=%b want 0/0/0/0", cpu_rvalid, dbg_rvalid, dbg_gnt, mem_re); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || cpu_rdata !== 16'h0) begin errors++; $display("[TB] FAIL rmid_discard: got cv=%b dv=%b data=%h want 0/0/0000", cpu_rvalid, dbg_rvalid, cpu_rdata); end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
      drive_dbg(1'b1, 1'b0, 16'h0040, 16'h0);
      #2;
      checks++; if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rmid_run%0d: got stall=%b gnt=%b want 0/0", k, cpu_stall, dbg_gnt); end
      @(negedge clk);
    end
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (dbg_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL rmid_load_ok: got gnt=%b cv=%b data=%h want 1/1/beef", dbg_gnt, cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL rmid_dbg_return: got dv=%b data=%h want 1/0000", dbg_rvalid, dbg_rdata); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit pending = 1'b0;
    logic exp_we, exp_re;
    logic [15:0] exp_addr, exp_wdata;
    halted = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (halted) halted = ($urandom_range(0, 3) != 0);
      else        halted = ($urandom_range(0, 29) == 0);
      drive_cpu(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 7)), 16'($urandom));
      if (!pending) drive_dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              16'($urandom_range(0, 7)), 16'($urandom));
      #2;
      exp_we    = (exp_cpu_won && cpu_we) || (exp_dbg_won && dbg_we);
      exp_re    = (exp_cpu_won && !cpu_we) || (exp_dbg_won && !dbg_we);
      exp_addr  = exp_dbg_won ? dbg_addr : cpu_addr;
      exp_wdata = exp_dbg_won ? dbg_wdata : cpu_wdata;
      checks++; if (cpu_stall !== (cpu_req && !exp_cpu_won)) begin errors++; $display("[TB] FAIL rnd_stall@%0d: got %b want %b", i, cpu_stall, cpu_req && !exp_cpu_won); end
      checks++; if (dbg_gnt !== exp_dbg_won) begin errors++; $display("[TB] FAIL rnd_gnt@%0d: got %b want %b", i, dbg_gnt, exp_dbg_won); end
      checks++; if (mem_we !== exp_we || mem_re !== exp_re) begin errors++; $display("[TB] FAIL rnd_we_re@%0d: got %b/%b want %b/%b", i, mem_we, mem_re, exp_we, exp_re); end
      if (exp_cpu_won || exp_dbg_won) begin
        checks++; if (mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL rnd_addr@%0d: got %h want %h", i, mem_addr, exp_addr); end
      end
      if (exp_we) begin
        checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("[TB] FAIL rnd_wdata@%0d: got %h want %h", i, mem_wdata, exp_wdata); end
      end
      checks++; if (cpu_rvalid !== m_cpu_rv || dbg_rvalid !== m_dbg_rv) begin errors++; $display("[TB] FAIL rnd_rvalid@%0d: got %b/%b want %b/%b", i, cpu_rvalid, dbg_rvalid, m_cpu_rv, m_dbg_rv); end
      checks++; if (cpu_rdata !== m_cpu_rd || dbg_rdata !== m_dbg_rd) begin errors++; $display("[TB] FAIL rnd_rdata@%0d: got %h/%h want %h/%h", i, cpu_rdata, dbg_rdata, m_cpu_rd, m_dbg_rd); end
      pending = dbg_req && !dbg_gnt;
      @(negedge clk);
    end
    halted = 1'b0;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    drive_dbg(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_load();
    test_starvation();
    test_store_then_read();
    test_halt_alternate();
    test_halt_writes();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported synchronous data RAM between the pipeline memory stage (cpu port) and the debug/boot loader (dbg port).
- Fixed priority to the cpu, with a starvation counter that guarantees dbg forward progress.
- Gives dbg exclusive access while the core is halted.
- Routes 1-cycle-latency read data back to whichever requester issued the read.

Parameters:
ADDR_W, 16, address width of both ports and the RAM
DATA_W, 16, data width
STARVE_MAX, 4, consecutive cycles dbg may wait while cpu wins before dbg is forced through once (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
halted  in  1  core halted (from the memory stage halt flag)
cpu_req  in  1  cpu access request, valid this cycle
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  cpu address
cpu_wdata  in  DATA_W  store data
cpu_stall  out  1  cpu request not serviced this cycle; pipeline must hold
cpu_rvalid  out  1  cpu load data valid (one cycle after the granted load)
cpu_rdata  out  DATA_W  cpu load data
dbg_req  in  1  dbg access request
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  dbg address
dbg_wdata  in  DATA_W  dbg write data
dbg_gnt  out  1  dbg request accepted this cycle
dbg_rvalid  out  1  dbg read data valid
dbg_rdata  out  DATA_W  dbg read data
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re

Behaviour:
- FSM states:
  - RUN: cpu priority.
  - FORCE: dbg priority for exactly one granted access.
  - HALT: dbg exclusive.
- Reset values:
  - state=RUN, starve_cnt=0, rd_owner=NONE.
  - cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
  - While rst is high, mem_we, mem_re and dbg_gnt are forced to 0 and cpu_stall=cpu_req.
- Grant decision is combinational within the cycle:
  - RUN: cpu wins if cpu_req, otherwise dbg wins if dbg_req.
  - FORCE: dbg wins if dbg_req, otherwise cpu wins if cpu_req.
  - HALT: dbg only; cpu never granted.
- Winner drives mem_addr, mem_wdata, mem_we=winner_we, mem_re=!winner_we.
- With no winner: mem_we=0, mem_re=0, mem_addr/mem_wdata hold the cpu values (don't-care).
- cpu_stall = cpu_req & !cpu_won.
- dbg_gnt = dbg_won. dbg must hold req/addr/data until it sees gnt.
- starve_cnt:
  - Increments when in RUN, dbg_req=1 and dbg not won.
  - Clears when dbg is granted or dbg_req=0.
  - Saturates at STARVE_MAX.
- Transitions, with priority top-down:
  - halted=1 -> HALT, from any state.
  - HALT with halted=0 -> RUN, with starve_cnt cleared.
  - RUN with starve_cnt==STARVE_MAX-1 and another dbg loss this cycle -> FORCE.
  - FORCE after the cycle in which dbg is granted -> RUN, with starve_cnt cleared.
  - FORCE with dbg_req dropped -> RUN.
- Read return:
  - rd_owner registers {NONE, CPU, DBG} from the winner when mem_re=1, otherwise NONE.
  - Next cycle, the owner's rvalid=1 and its rdata <= mem_rdata, registered through the output so rdata holds until the next read.
  - The other rvalid=0.
  - Back-to-back reads from alternating owners each get their own rvalid with no gap.
- Writes produce no rvalid.
- Simultaneous cpu_req and dbg_req in FORCE: dbg granted, cpu stalled one cycle.
- halted rising in the same cycle as a cpu grant: that access completes. HALT takes effect from the next cycle.
- Reset mid-operation: a pending read is discarded and no rvalid is issued after reset deasserts. FSM returns to RUN.

Test Plan:
- cpu load addr 0x0010 (RAM holds 0xBEEF), no dbg -> mem_re=1 same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF.
- cpu_req held high for 6 cycles, dbg write 0x0020<-0x1234 held, STARVE_MAX=4:
  - dbg loses cycles 0-3.
  - cycle 4: FORCE, dbg_gnt=1, mem_we=1 with addr 0x0020, cpu_stall=1.
  - cycle 5: RUN, cpu granted.
- Alternating cpu read 0x0001 and dbg read 0x0002 with halted=1 then 0 -> in HALT cpu_stall=1 and dbg serviced; after release cpu read returns via cpu_rvalid only and dbg read via dbg_rvalid only.
- halted=1, dbg writes 0x0000..0x0003 on consecutive cycles -> dbg_gnt=1 every cycle and mem_we pulses 4 times; a cpu_req asserted meanwhile stays stalled.
- cpu load granted, rst pulsed in the following cycle -> cpu_rvalid and dbg_rvalid stay 0, state RUN, starve_cnt=0, and the next cpu load completes normally.
- Simultaneous cpu store 0x0005<-0xAAAA and dbg read 0x0005 in RUN -> store first with dbg_gnt=0; next cycle dbg granted and dbg_rdata=0xAAAA one cycle later.
